fir_sample_loader: RTL and testbench
====================================

Name: fir_sample_loader

Overview:
- Upstream stage of the FIR test datapath.
- On a button edge, fills the shared BRAM input region with a selectable deterministic test pattern through a write port.
- Then issues a one-cycle start to the selected FIR filter and supervises its completion with a watchdog.
- Replaces manual BRAM preloading so both filter variants run on identical, reproducible stimulus.

Parameters:
- ADDR_W, 10, BRAM address width.
- DATA_W, 8, sample width (pattern logic is defined for 8 bits only).
- BASE_ADDR, 0, first input sample address.
- SAMPLE_COUNT, 20, number of samples written; constraint BASE_ADDR+SAMPLE_COUNT <= 2**ADDR_W.
- LFSR_SEED, 8'hA5, LFSR seed; must be nonzero.
- TIMEOUT_CYCLES, 4096, max cycles from fir_start to fir_done rising edge.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- go  in  1  run request, level; rising edge detected internally.
- pattern_sel  in  2  0=ramp, 1=LFSR, 2=impulse, 3=step.
- fir_done  in  1  completion from the muxed filter.
- mem_addr  out  ADDR_W  BRAM write address.
- mem_wdata  out  DATA_W  BRAM write data.
- mem_we  out  1  BRAM write enable.
- fir_start  out  1  one-cycle start pulse to the filter.
- busy  out  1  high in FILL, ARM and WAIT.
- run_ok  out  1  one-cycle pulse on a completed run.
- timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (async): state IDLE; all outputs 0; go_prev=0, done_prev=0, idx=0, wdog=0, lfsr=LFSR_SEED.
- States: IDLE, FILL, ARM, WAIT, all registered. Every output is a registered or pure state decode, with no combinational path from inputs.
- IDLE:
  - On a clock edge with go=1 and go_prev=0: latch pattern_sel, idx=0, lfsr=LFSR_SEED, clear timeout, go to FILL.
  - If SAMPLE_COUNT==0, go directly to ARM instead.
- FILL:
  - Each cycle: mem_we=1, mem_addr=BASE_ADDR+idx, mem_wdata=pattern(idx).
  - After the write with idx==SAMPLE_COUNT-1, go to ARM. Exactly SAMPLE_COUNT consecutive write cycles.
- Patterns (8-bit):
  - Ramp: idx[7:0], wrapping modulo 256.
  - LFSR: current lfsr value. Galois right shift, taps 8'hB8: next = (lfsr>>1) ^ (lfsr[0] ? 8'hB8 : 0). Advances after each write; the first sample is the seed.
  - Impulse: 8'h7F at idx 0, else 8'h00.
  - Step: 8'h40 for all samples.
- ARM:
  - One cycle with fir_start=1 and mem_we=0, so the last write has already landed in BRAM.
  - Clear wdog, go to WAIT.
- WAIT:
  - wdog increments each cycle.
  - A fir_done rising edge (fir_done=1, done_prev=0) pulses run_ok for one cycle and returns to IDLE. A level-high fir_done left over from a previous run is ignored.
  - If wdog reaches TIMEOUT_CYCLES-1 with no edge: set timeout and return to IDLE.
  - If the edge and the timeout occur in the same cycle, the edge wins: run_ok=1, timeout stays 0.
- Latency from the go edge at clock N:
  - Writes occur in cycles N+1..N+SAMPLE_COUNT.
  - fir_start is high in cycle N+SAMPLE_COUNT+1.
  - WAIT begins at N+SAMPLE_COUNT+2.
- Ignored inputs: go edges outside IDLE, and pattern_sel changes after the latch.
- Reset mid-operation: mem_we and fir_start drop immediately. A partial fill is acceptable; no recovery is attempted.
- Widths: idx is clog2(SAMPLE_COUNT+1) bits; wdog is clog2(TIMEOUT_CYCLES) bits and saturates.

Decomposition:
- Shared package fir_pkg: state encoding, pattern_sel codes (PAT_RAMP..PAT_STEP), LFSR_TAPS=8'hB8, IMPULSE_AMP=8'h7F, STEP_LEVEL=8'h40.
- One sub-module, fir_pattern_gen: holds the lfsr register and does the pattern select. Inputs: clk, rst, load, advance, sel, idx. Output: data.
- The FSM, edge detectors and watchdog stay in fir_sample_loader.

Test Plan:
- Ramp, defaults: go edge -> 20 writes to addr 0..19 with data 0..19 in consecutive cycles; fir_start high exactly 1 cycle, 1 cycle after the last write; busy=1 throughout.
- LFSR: pattern_sel=1 -> first four writes 0xA5, 0xEA, 0x75, 0x82.
- Impulse then step: addr 0 = 0x7F, addrs 1..19 = 0x00; a second run with step writes 0x40 to all 20 addresses.
- Done handshake: fir_done held high before start, then dropped, then raised 50 cycles after fir_start -> run_ok pulses once on the rise; the pre-existing high level causes no pulse.
- Watchdog: TIMEOUT_CYCLES=16, fir_done stuck at 0 -> timeout=1 16 cycles after fir_start, state IDLE; the next go edge clears timeout. Separately, a fir_done edge in the final watchdog cycle -> run_ok=1, timeout=0.
- Reset during FILL at idx=7: mem_we=0 immediately; all outputs 0; a go edge during busy is ignored; a fresh go after reset restarts at addr 0.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR test-stimulus loader.
// Holds the FSM encoding, the pattern codes and the pattern constants.
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_ARM  = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    PAT_RAMP    = 2'd0,
    PAT_LFSR    = 2'd1,
    PAT_IMPULSE = 2'd2,
    PAT_STEP    = 2'd3
  } pat_sel_t;

  localparam logic [7:0] LFSR_TAPS   = 8'hB8;
  localparam logic [7:0] IMPULSE_AMP = 8'h7F;
  localparam logic [7:0] STEP_LEVEL  = 8'h40;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/fir_sample_loader_if.sv
// BRAM write port plus filter start/done handshake.
// The master side is the loader; the slave side is BRAM + filter.
interface fir_sample_loader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              fir_start;
  logic              fir_done;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we,
    output fir_start,
    input  fir_done
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    input  fir_start,
    output fir_done
  );
endinterface

// File: rtl/fir_pattern_gen.sv
// Deterministic 8-bit test pattern source.
// Owns the LFSR state; the other patterns are pure functions of idx.
module fir_pattern_gen
  import fir_pkg::*;
#(
  parameter int         IDX_W = 5,
  parameter logic [7:0] SEED  = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  input  pat_sel_t         sel,
  input  logic [IDX_W-1:0] idx,
  output logic [7:0]       data
);

  logic [7:0] lfsr;

  // LFSR: reseeded at run start, stepped once per written sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= SEED;
    end else if (load) begin
      lfsr <= SEED;
    end else if (advance) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  // Pattern select
  always_comb begin
    data = 8'h00;
    unique case (sel)
      PAT_RAMP:    data = 8'(idx);
      PAT_LFSR:    data = lfsr;
      PAT_IMPULSE: data = (idx == '0) ? IMPULSE_AMP : 8'h00;
      PAT_STEP:    data = STEP_LEVEL;
    endcase
  end

endmodule

// File: rtl/fir_sample_loader.sv
// Fills the FIR input region of BRAM with a test pattern, then starts
// the filter and watches for its done edge under a watchdog.
module fir_sample_loader
  import fir_pkg::*;
#(
  parameter int         ADDR_W         = 10,
  parameter int         DATA_W         = 8,
  parameter int         BASE_ADDR      = 0,
  parameter int         SAMPLE_COUNT   = 20,
  parameter logic [7:0] LFSR_SEED      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [1:0] pattern_sel,
  fir_sample_loader_if.master bus,
  output logic       busy,
  output logic       run_ok,
  output logic       timeout
);

  localparam int IDX_W =
    (SAMPLE_COUNT > 0) ? $clog2(SAMPLE_COUNT + 1) : 1;
  localparam int WDOG_W =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t            state;
  state_t            state_nxt;
  pat_sel_t          sel_q;
  logic [IDX_W-1:0]  idx;
  logic [WDOG_W-1:0] wdog;
  logic              go_prev;
  logic              done_prev;
  logic              go_edge;
  logic              done_edge;
  logic              last;
  logic              wdog_exp;
  logic              pat_load;
  logic [7:0]        pat;

  assign go_edge   = go & ~go_prev;
  assign done_edge = bus.fir_done & ~done_prev;
  assign last      = (idx == IDX_W'(SAMPLE_COUNT - 1));
  assign wdog_exp  = (wdog == WDOG_W'(TIMEOUT_CYCLES - 1));
  assign pat_load  = (state == ST_IDLE) && go_edge;

  fir_pattern_gen #(
    .IDX_W (IDX_W),
    .SEED  (LFSR_SEED)
  ) u_pat (
    .clk     (clk),
    .rst     (rst),
    .load    (pat_load),
    .advance (state == ST_FILL),
    .sel     (sel_q),
    .idx     (idx),
    .data    (pat)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (go_edge)
        state_nxt = (SAMPLE_COUNT == 0) ? ST_ARM : ST_FILL;
      ST_FILL: if (last) state_nxt = ST_ARM;
      ST_ARM:  state_nxt = ST_WAIT;
      ST_WAIT: if (done_edge || wdog_exp) state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: edge history, index, watchdog and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      go_prev   <= 1'b0;
      done_prev <= 1'b0;
      sel_q     <= PAT_RAMP;
      idx       <= '0;
      wdog      <= '0;
      run_ok    <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      go_prev   <= go;
      done_prev <= bus.fir_done;
      run_ok    <= 1'b0;
      unique case (state)
        ST_IDLE: if (go_edge) begin
          sel_q   <= pat_sel_t'(pattern_sel);
          idx     <= '0;
          timeout <= 1'b0;
        end
        ST_FILL: idx <= idx + 1'b1;
        ST_ARM:  wdog <= '0;
        ST_WAIT: begin
          if (wdog != '1) wdog <= wdog + 1'b1;
          if (done_edge)     run_ok  <= 1'b1;
          else if (wdog_exp) timeout <= 1'b1;
        end
      endcase
    end
  end

  // Write port and start are pure decodes of the registered state
  always_comb begin
    bus.mem_we    = (state == ST_FILL);
    bus.fir_start = (state == ST_ARM);
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (state == ST_FILL) begin
      bus.mem_addr  = ADDR_W'(BASE_ADDR) + ADDR_W'(idx);
      bus.mem_wdata = DATA_W'(pat);
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_fir_sample_loader.sv
// Directed bench for fir_sample_loader: patterns, handshake,
// watchdog and mid-fill reset, on a default and a short-timeout instance.
module tb_fir_sample_loader;

  logic       clk;
  logic       rst;
  logic       go_a, go_b;
  logic [1:0] sel_a, sel_b;
  logic       busy_a, busy_b;
  logic       ok_a, ok_b;
  logic       to_a, to_b;
  int         n_cmp;
  int         n_err;

  fir_sample_loader_if #(.ADDR_W(10), .DATA_W(8)) bus_a ();
  fir_sample_loader_if #(.ADDR_W(10), .DATA_W(8)) bus_b ();

  fir_sample_loader u_a (
    .clk         (clk),
    .rst         (rst),
    .go          (go_a),
    .pattern_sel (sel_a),
    .bus         (bus_a.master),
    .busy        (busy_a),
    .run_ok      (ok_a),
    .timeout     (to_a)
  );

  fir_sample_loader #(.TIMEOUT_CYCLES(16)) u_b (
    .clk         (clk),
    .rst         (rst),
    .go          (go_b),
    .pattern_sel (sel_b),
    .bus         (bus_b.master),
    .busy        (busy_b),
    .run_ok      (ok_b),
    .timeout     (to_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_data(input logic [1:0] s,
                                          input int i);
    logic [7:0] tab [4];
    tab = '{8'hA5, 8'hEA, 8'h75, 8'h82};
    case (s)
      2'd0:    return 8'(i);
      2'd1:    return tab[i];
      2'd2:    return (i == 0) ? 8'h7F : 8'h00;
      default: return 8'h40;
    endcase
  endfunction

  // go edge, 20 checked writes, returns in the fir_start cycle
  task automatic fill_a(input logic [1:0] s);
    sel_a = s;
    go_a  = 1'b1;
    step();
    go_a  = 1'b0;
    sel_a = ~s;
    for (int i = 0; i < 20; i++) begin
      chk("we", bus_a.mem_we, 1);
      chk("addr", bus_a.mem_addr, i);
      if (!(s == 2'd1 && i >= 4))
        chk("data", bus_a.mem_wdata, exp_data(s, i));
      chk("busy_fill", busy_a, 1);
      chk("start_early", bus_a.fir_start, 0);
      step();
    end
    chk("start", bus_a.fir_start, 1);
    chk("we_arm", bus_a.mem_we, 0);
    chk("busy_arm", busy_a, 1);
  endtask

  // called in the fir_start cycle; produces a clean done edge
  task automatic finish_a();
    bus_a.fir_done = 1'b0;
    step();
    chk("start_1cyc", bus_a.fir_start, 0);
    bus_a.fir_done = 1'b1;
    step();
    chk("ok_fin", ok_a, 1);
    chk("busy_fin", busy_a, 0);
  endtask

  initial begin
    int hits;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    go_a = 1'b0;
    go_b = 1'b0;
    sel_a = 2'd0;
    sel_b = 2'd0;
    bus_a.fir_done = 1'b0;
    bus_b.fir_done = 1'b0;
    #3;
    chk("rst_we", bus_a.mem_we, 0);
    chk("rst_start", bus_a.fir_start, 0);
    chk("rst_addr", bus_a.mem_addr, 0);
    chk("rst_wdata", bus_a.mem_wdata, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_ok", ok_a, 0);
    chk("rst_to", to_a, 0);
    step();
    rst = 1'b0;
    step();

    // ramp run with fir_done held high before start
    bus_a.fir_done = 1'b1;
    fill_a(2'd0);
    step();
    chk("start_drop", bus_a.fir_start, 0);
    chk("busy_wait", busy_a, 1);
    bus_a.fir_done = 1'b0;
    hits = 0;
    for (int k = 2; k <= 50; k++) begin
      step();
      if (ok_a !== 1'b0 || busy_a !== 1'b1) hits++;
    end
    chk("no_early_ok", hits, 0);
    bus_a.fir_done = 1'b1;
    step();
    chk("ok_pulse", ok_a, 1);
    chk("idle_after", busy_a, 0);
    chk("to_clear", to_a, 0);
    step();
    chk("ok_1cyc", ok_a, 0);

    // lfsr, impulse, step (done left high from previous run)
    fill_a(2'd1);
    finish_a();
    fill_a(2'd2);
    finish_a();
    fill_a(2'd3);
    finish_a();

    // reset mid-fill; go edge during busy ignored
    step();
    sel_a = 2'd0;
    go_a  = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      chk("rs_addr", bus_a.mem_addr, i);
      chk("rs_we", bus_a.mem_we, 1);
      if (i == 2) go_a = 1'b0;
      if (i == 3) go_a = 1'b1;
      if (i < 7) step();
    end
    #2 rst = 1'b1;
    #1;
    chk("rs_we0", bus_a.mem_we, 0);
    chk("rs_start0", bus_a.fir_start, 0);
    chk("rs_addr0", bus_a.mem_addr, 0);
    chk("rs_busy0", busy_a, 0);
    chk("rs_ok0", ok_a, 0);
    chk("rs_to0", to_a, 0);
    go_a = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("rs_idle", busy_a, 0);
    fill_a(2'd0);
    finish_a();

    // watchdog expiry on the short-timeout instance
    sel_b = 2'd0;
    go_b  = 1'b1;
    step();
    go_b  = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("wd_start", bus_b.fir_start, 1);
    for (int k = 1; k <= 16; k++) step();
    chk("wd_to_early", to_b, 0);
    chk("wd_busy", busy_b, 1);
    step();
    chk("wd_to", to_b, 1);
    chk("wd_idle", busy_b, 0);
    chk("wd_ok", ok_b, 0);
    go_b = 1'b1;
    step();
    go_b = 1'b0;
    chk("wd_to_clr", to_b, 0);
    chk("wd_busy2", busy_b, 1);

    // done edge in the last watchdog cycle wins
    for (int i = 1; i < 21; i++) step();
    chk("wd_start2", bus_b.fir_start, 1);
    for (int k = 1; k <= 16; k++) step();
    chk("race_to0", to_b, 0);
    bus_b.fir_done = 1'b1;
    step();
    chk("race_ok", ok_b, 1);
    chk("race_to", to_b, 0);
    chk("race_idle", busy_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
